// File: rtl/display_scan_4digit_pkg.sv
// Shared types and constants for the 4-digit multiplexed display scanner.
// The scan FSM state is exported so checkers can observe it.
package display_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_4digit_if.sv
// Load handshake and digit-drive bundle for display_scan_4digit.
// Handshake: a transfer happens on a rising edge where load_valid && load_ready.
interface display_scan_4digit_if;
  import display_scan_pkg::*;

  logic                  load_valid;
  logic                  load_ready;
  logic [VALUE_W-1:0]    value;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  lz_blank_en;
  logic [NIBBLE_W-1:0]   nibble;
  logic                  dp;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  frame_done;

  modport master (
    output load_valid, value, dp_in, lz_blank_en,
    input  load_ready, nibble, dp, digit_en, frame_done
  );

  modport slave (
    input  load_valid, value, dp_in, lz_blank_en,
    output load_ready, nibble, dp, digit_en, frame_done
  );

endinterface

// File: rtl/display_scan_4digit_scan_prescaler.sv
// Per-digit slot counter: counts 0..DIV_MAX and flags the slot end and
// the anti-ghost blanking window at the start of each slot.
module scan_prescaler #(
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end,
  output logic in_blank,
  output logic blank_last
);

  localparam int CNT_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    slot_end   = (cnt_q == CNT_W'(DIV_MAX));
    in_blank   = (cnt_q <  CNT_W'(BLANK_CYCLES));
    blank_last = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_4digit.sv
// Multiplexed 4-digit display scanner with tear-free value updates:
// new values wait in a shadow register until the end of the frame.
module display_scan_4digit
  import display_scan_pkg::*;
#(
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scan_4digit_if.slave  bus,
  output scan_state_t           dbg_state
);

  logic slot_end;
  logic in_blank;
  logic blank_last;

  scan_prescaler #(
    .DIV_MAX      (DIV_MAX),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_end   (slot_end),
    .in_blank   (in_blank),
    .blank_last (blank_last)
  );

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  pending_q, pending_d;
  logic [VALUE_W-1:0]    shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VALUE_W-1:0]    disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  xfer;
  logic                  commit;
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  suppress;

  // State register: tracks the slot counter, so it is always S_BLANK while
  // the counter sits below BLANK_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state is derived from the counter's next value.
  always_comb begin
    state_d = S_SHOW;
    if (slot_end || (in_blank && !blank_last)) begin
      state_d = S_BLANK;
    end
  end

  // Load path and digit sequencing.
  always_comb begin
    xfer         = bus.load_valid && !pending_q;
    commit       = slot_end && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
    digit_idx_d  = slot_end ? digit_idx_q + IDX_W'(1) : digit_idx_q;
    pending_d    = pending_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (commit) begin
      if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
        pending_d  = 1'b0;
      end else if (xfer) begin
        // Loading straight into the display keeps pending clear at the frame edge.
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
      end
    end else if (xfer) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp_in;
      pending_d    = 1'b1;
    end
  end

  // Output logic: zero_from[k] is set when display nibbles k..top are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (disp_val_q[VALUE_W-1 -: NIBBLE_W] == '0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (disp_val_q[k*NIBBLE_W +: NIBBLE_W] == '0);
    end
    suppress     = bus.lz_blank_en && (digit_idx_q != '0) && zero_from[digit_idx_q];
    nibble_d     = disp_val_q[digit_idx_q*NIBBLE_W +: NIBBLE_W];
    dp_d         = disp_dp_q[digit_idx_q];
    digit_en_d   = '0;
    if ((state_q == S_SHOW) && !suppress) begin
      digit_en_d = NUM_DIGITS'(1) << digit_idx_q;
    end
    frame_done_d = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx_q  <= '0;
      pending_q    <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      nibble_q     <= '0;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      digit_idx_q  <= digit_idx_d;
      pending_q    <= pending_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.load_ready = ~pending_q;
  assign bus.nibble     = nibble_q;
  assign bus.dp         = dp_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_done = frame_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_display_scan_4digit.sv
// Bench for display_scan_4digit: directed scenarios plus random loads,
// checked every cycle against a frame-arithmetic reference model.
module tb_display_scan_4digit;
  import display_scan_pkg::*;

  localparam int DIV_MAX = 9;
  localparam int BLANK   = 2;
  localparam int SLOT    = DIV_MAX + 1;
  localparam int FRAME   = SLOT * NUM_DIGITS;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_4digit_if bus ();
  scan_state_t dbg_state;

  display_scan_4digit #(
    .DIV_MAX      (DIV_MAX),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // reference model: cycles since reset release plus display/shadow contents
  int unsigned  c;
  logic [15:0]  m_disp, m_shadow;
  logic [3:0]   m_disp_dp, m_shadow_dp;
  bit           m_pend;

  // scoreboard
  logic [9:0]   exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    c           = 0;
    m_disp      = '0;
    m_shadow    = '0;
    m_disp_dp   = '0;
    m_shadow_dp = '0;
    m_pend      = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string when);
    check_eq({when, "_nibble"},     16'(bus.nibble),     16'h0);
    check_eq({when, "_dp"},         16'(bus.dp),         16'h0);
    check_eq({when, "_digit_en"},   16'(bus.digit_en),   16'h0);
    check_eq({when, "_frame_done"}, 16'(bus.frame_done), 16'h0);
    check_eq({when, "_load_ready"}, 16'(bus.load_ready), 16'h1);
    check_eq({when, "_state"},      16'(dbg_state),      16'(S_BLANK));
  endtask

  // asynchronous reset applied between clock edges
  task automatic do_reset();
    bus.load_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: one clock with the given inputs, then compare against the model
  task automatic step(input bit lv, input logic [15:0] val, input logic [3:0] dpi, input bit lz);
    int          cnt, idx;
    bit          fd, sup, xfer;
    logic [3:0]  en, nib;
    logic [9:0]  e;
    bus.load_valid  = lv;
    bus.value       = val;
    bus.dp_in       = dpi;
    bus.lz_blank_en = lz;
    cnt = int'(c % SLOT);
    idx = int'((c / SLOT) % NUM_DIGITS);
    en  = '0;
    if (cnt >= BLANK) begin
      sup = lz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
      if (!sup) en = 4'(1 << idx);
    end
    nib = 4'(m_disp >> (4 * idx));
    fd  = (cnt == DIV_MAX) && (idx == NUM_DIGITS - 1);
    exp_q.push_back({fd, m_disp_dp[idx], nib, en});
    xfer = lv && !m_pend;
    if (fd) begin
      if (m_pend) begin
        m_disp    = m_shadow;
        m_disp_dp = m_shadow_dp;
        m_pend    = 1'b0;
      end else if (xfer) begin
        m_disp    = val;
        m_disp_dp = dpi;
      end
    end else if (xfer) begin
      m_shadow    = val;
      m_shadow_dp = dpi;
      m_pend      = 1'b1;
    end
    c++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("digit_en",   16'(bus.digit_en),   16'(e[3:0]));
    check_eq("nibble",     16'(bus.nibble),     16'(e[7:4]));
    check_eq("dp",         16'(bus.dp),         16'(e[8]));
    check_eq("frame_done", 16'(bus.frame_done), 16'(e[9]));
    check_eq("load_ready", 16'(bus.load_ready), 16'(!m_pend));
    check_eq("state",      16'(dbg_state),
             16'(((c % SLOT) < BLANK) ? S_BLANK : S_SHOW));
  endtask

  task automatic idle(input int n, input bit lz);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, lz);
  endtask

  initial begin
    logic [31:0] v;
    int          nz;
    bit          lz;
    bus.load_valid  = 1'b0;
    bus.value       = '0;
    bus.dp_in       = '0;
    bus.lz_blank_en = 1'b0;
    model_reset();

    do_reset();
    idle(FRAME + 10, 1'b0);

    // mid-frame load of 0x1234 with dp on digit 2
    for (int i = 0; i < FRAME && (c % FRAME) != 15; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(2 * FRAME, 1'b0);

    // leading-zero suppression on and off
    step(1'b1, 16'h0007, 4'b0000, 1'b1);
    idle(2 * FRAME + 20, 1'b1);
    idle(FRAME + 10, 1'b0);

    // load exactly on the commit cycle
    for (int i = 0; i < 2 * FRAME && !(((c % FRAME) == FRAME - 1) && !m_pend); i++)
      step(1'b0, 16'h0, 4'h0, 1'b0);
    check_eq("commit_align", 16'(c % FRAME), 16'(FRAME - 1));
    step(1'b1, 16'hABCD, 4'b1010, 1'b0);
    idle(FRAME + 5, 1'b0);

    // second load offered while the first is pending
    step(1'b1, 16'h1111, 4'b0001, 1'b0);
    step(1'b1, 16'h2222, 4'b1000, 1'b0);
    idle(2 * FRAME, 1'b0);

    // random loads with random leading zeros and lz toggling
    lz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      v  = $urandom;
      nz = $urandom_range(0, 4);
      v  = v & ((32'h1 << (4 * (4 - nz))) - 32'h1);
      if ($urandom_range(0, 99) == 0) lz = !lz;
      step($urandom_range(0, 7) == 0, v[15:0], 4'($urandom_range(0, 15)), lz);
    end

    // reset during digit 2 with a value pending
    for (int i = 0; i < 3 * FRAME && !((((c / SLOT) % NUM_DIGITS) == 2) && ((c % SLOT) == 1) && !m_pend); i++)
      step(1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 16'h5A5A, 4'hF, 1'b0);
    check_eq("pend_before_rst", 16'(bus.load_ready), 16'h0);
    idle(3, 1'b0);
    do_reset();
    idle(FRAME + 20, 1'b0);
    idle(FRAME, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_4digit.md
DISPLAY_SCAN_4DIGIT -- requirements
Module: display_scan_4digit

Interface
REQ-001 SHALL have parameter DIV_MAX, default 49999, meaning the last count of the per-digit slot; a slot lasts DIV_MAX+1 clk cycles.
REQ-002 SHALL have parameter BLANK_CYCLES, default 4, meaning the anti-ghost blank cycles at the start of each slot; legal range 1..DIV_MAX.
REQ-003 SHALL use one clock and one reset: clk is the single clock; rst_n is an asynchronous, active-low reset.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 load_valid  in  1  upstream offers a new 16-bit value.
REQ-007 load_ready  out  1  block can accept a value.
REQ-008 value  in  16  four BCD/hex nibbles; [3:0] is digit 0, the least significant digit.
REQ-009 dp_in  in  4  decimal point per digit, captured together with value.
REQ-010 lz_blank_en  in  1  leading-zero blanking enable; sampled live.
REQ-011 nibble  out  4  current digit code, fed to the downstream 7-segment decoder.
REQ-012 dp  out  1  decimal point of the current digit.
REQ-013 digit_en  out  4  one-hot active-high digit enable; all-zero when blanked.
REQ-014 frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-015 Slot counter SHALL count 0..DIV_MAX, then wrap to 0; each wrap SHALL advance digit_idx 0→1→2→3→0.
REQ-016 FSM SHALL have states S_BLANK (counter < BLANK_CYCLES) and S_SHOW (counter ≥ BLANK_CYCLES); state is a function of the counter value.
REQ-017 In S_BLANK, digit_en SHALL be 0000.
REQ-018 In S_SHOW, digit_en SHALL equal 1<<digit_idx unless that digit is suppressed (REQ-019).
REQ-019 Leading-zero suppression: with lz_blank_en=1, digit k>0 SHALL be suppressed when display nibbles k..3 are all zero; digit 0 SHALL never be suppressed.
REQ-020 nibble and dp SHALL show display-register digit digit_idx in every state.
REQ-021 nibble, dp and digit_en SHALL be registered, with one cycle of latency relative to counter/digit_idx.
REQ-022 A transfer SHALL occur when load_valid and load_ready are both high on a rising edge.
REQ-023 load_ready SHALL equal NOT pending.
REQ-024 A transfer SHALL capture value and dp_in into the shadow register and set pending.
REQ-025 Commit point is the cycle with counter==DIV_MAX and digit_idx==3.
  - If pending, the display register SHALL load the shadow register and pending SHALL clear.
  - If a transfer happens on the commit cycle, pending is 0 by definition; the display register SHALL load value/dp_in directly and pending SHALL stay 0.
  - Display updates therefore never tear mid-frame.
REQ-026 frame_done SHALL pulse in the cycle after the commit point.
REQ-027 load_valid held low SHALL leave all registers except the counter, digit_idx and outputs unchanged.

Reset
REQ-028 While rst_n=0, the following SHALL hold asynchronously:
  - counter=0, digit_idx=0, state S_BLANK;
  - display and shadow registers=0, pending=0;
  - load_ready=1, nibble=0, dp=0, digit_en=0000, frame_done=0.
REQ-029 Reset asserted mid-frame or mid-transfer SHALL discard pending data; scanning SHALL restart from digit 0, S_BLANK, on the first edge after release.

Structure
REQ-030 Package display_scan_pkg SHALL hold:
  - the state enum (S_BLANK, S_SHOW);
  - constants NUM_DIGITS=4 and NIBBLE_W=4.
REQ-031 Sub-module scan_prescaler SHALL contain the slot counter and provide slot_end and in_blank flags; all other logic stays in the top.
REQ-032 Implementation SHALL be 120-400 RTL lines and contain no combinational path from inputs to outputs other than load_ready.

Verification (DIV_MAX=9, BLANK_CYCLES=2; slot=10, frame=40 cycles)
REQ-033 Reset release, no load → digit_en cycles 0000×2 then 0001×8, then 0000×2/0010×8, etc.; nibble=0; frame_done every 40 cycles.
REQ-034 Load 0x1234, dp_in=0100, mid-frame → load_ready=0 until the commit point; the next frame shows digit0=4, digit1=3, digit2=2 with dp=1, digit3=1; load_ready returns to 1.
REQ-035 Load 0x0007, lz_blank_en=1 → only digit 0 is enabled (nibble 7); digits 1-3 stay 0000 during S_SHOW. lz_blank_en=0 → all four digits enabled.
REQ-036 load_valid pulsed on the exact commit cycle with 0xABCD → the next frame shows 0xABCD; pending never sets.
REQ-037 Second load while pending (ready=0) → no transfer; the first value is displayed.
REQ-038 rst_n pulsed low during digit 2 with pending=1 → outputs go to reset values immediately; the display shows 0000 after release.
